// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and fetch sequencer; a redirect that arrives while
// the instruction memory is still busy is parked in pend_pc until that fetch completes.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic        if_flush,
  input  logic [31:0] id_pc4,
  input  logic [25:0] j_index,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic [15:0] redirect_cnt
);
  typedef enum logic [1:0] {BOOT, FETCH, PEND} state_t;
  state_t      state;
  logic [31:0] pend_pc, target;
  logic        redirect, go;
  assign redirect   = if_flush & (pc_src != 2'b00);
  assign target     = (pc_src == 2'b01) ? {id_pc4[31:28], j_index, 2'b00} :
                      (pc_src == 2'b10) ? br_target : jr_addr;
  assign go         = imem_ready & ~stall;
  assign pc_plus4   = pc + 32'd4;
  assign imem_req   = state != BOOT;
  assign ifid_write = imem_req & go;
  // In PEND the completing fetch is the stale one, so it is squashed as it lands.
  assign ifid_flush = go & (((state == FETCH) & redirect) | (state == PEND));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pend_pc      <= 32'd0;
      redirect_cnt <= 16'd0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: if (!stall) begin
          if (imem_ready) pc <= redirect ? target : pc_plus4;
          else if (redirect) begin
            pend_pc <= target;
            state   <= PEND;
          end
          if (redirect && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
        end
        PEND: if (go) begin
          pc    <= pend_pc;
          state <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table plus hand sequences for pending redirects,
// stall, asynchronous reset and counter saturation.
module tb_pc_fetch_ctrl;
  logic        clk = 0, rst = 1;
  logic [1:0]  pc_src = 0;
  logic        if_flush = 0, stall = 0, imem_ready = 1;
  logic [31:0] id_pc4 = 32'h9000_0010, br_target = 32'h200, jr_addr = 32'h300;
  logic [25:0] j_index = 26'h000_0123;
  logic        imem_req, ifid_write, ifid_flush;
  logic [31:0] pc, pc_plus4;
  logic [15:0] redirect_cnt;
  int n_chk = 0, n_fail = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .if_flush(if_flush), .id_pc4(id_pc4),
    .j_index(j_index), .br_target(br_target), .jr_addr(jr_addr), .stall(stall),
    .imem_ready(imem_ready), .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, r, f;
    logic [1:0]  src;
    logic        w, ff;
    logic [31:0] pc;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic f, input logic [1:0] src);
    stall = s; imem_ready = r; if_flush = f; pc_src = src;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic reset_boot;
    step();
    rst = 1;
    drive(0, 1, 0, 2'b00);
    step();
    rst = 0;
    step();
  endtask

  initial begin
    // targets: j -> 0x9000_048C, br -> 0x200, jr -> 0x300
    tbl[0]  = '{0, 1, 0, 2'b00, 1, 0, 32'h4,         16'd0};
    tbl[1]  = '{0, 1, 0, 2'b00, 1, 0, 32'h8,         16'd0};
    tbl[2]  = '{0, 1, 0, 2'b00, 1, 0, 32'hC,         16'd0};
    tbl[3]  = '{0, 1, 1, 2'b00, 1, 0, 32'h10,        16'd0};
    tbl[4]  = '{0, 1, 0, 2'b10, 1, 0, 32'h14,        16'd0};
    tbl[5]  = '{0, 0, 0, 2'b00, 0, 0, 32'h14,        16'd0};
    tbl[6]  = '{0, 1, 1, 2'b01, 1, 1, 32'h9000_048C, 16'd1};
    tbl[7]  = '{1, 1, 1, 2'b11, 0, 0, 32'h9000_048C, 16'd1};
    tbl[8]  = '{0, 1, 1, 2'b11, 1, 1, 32'h300,       16'd2};
    tbl[9]  = '{0, 0, 1, 2'b10, 0, 0, 32'h300,       16'd3};
    tbl[10] = '{0, 0, 1, 2'b11, 0, 0, 32'h300,       16'd3};
    tbl[11] = '{1, 1, 0, 2'b00, 0, 0, 32'h300,       16'd3};
    tbl[12] = '{0, 1, 1, 2'b01, 1, 1, 32'h200,       16'd3};
    tbl[13] = '{0, 1, 0, 2'b00, 1, 0, 32'h204,       16'd3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_write", {31'd0, ifid_write}, 0);
    chk("rst_flush", {31'd0, ifid_flush}, 0);
    chk("rst_cnt", {16'd0, redirect_cnt}, 0);
    rst = 0;
    @(negedge clk);
    chk("boot_req", {31'd0, imem_req}, 0);
    chk("boot_write", {31'd0, ifid_write}, 0);
    step();
    chk("boot_pc", pc, 32'h0);
    chk("pc_plus4", pc_plus4, 32'h4);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].s, tbl[i].r, tbl[i].f, tbl[i].src);
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, 1);
      chk($sformatf("v%0d_write", i), {31'd0, ifid_write}, {31'd0, tbl[i].w});
      chk($sformatf("v%0d_flush", i), {31'd0, ifid_flush}, {31'd0, tbl[i].ff});
      step();
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d_cnt", i), {16'd0, redirect_cnt}, {16'd0, tbl[i].cnt});
    end

    // jump from pc 0x40
    reset_boot();
    repeat (16) step();
    chk("j_pc_before", pc, 32'h40);
    drive(0, 1, 1, 2'b01);
    @(negedge clk);
    chk("j_flush", {31'd0, ifid_flush}, 1);
    step();
    chk("j_pc", pc, 32'h9000_048C);
    chk("j_cnt", {16'd0, redirect_cnt}, 1);

    // branch from 0x80 while memory is busy for three cycles
    reset_boot();
    repeat (32) step();
    chk("br_pc_before", pc, 32'h80);
    drive(0, 0, 1, 2'b10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("pend%0d_flush", k), {31'd0, ifid_flush}, 0);
      step();
      chk($sformatf("pend%0d_pc", k), pc, 32'h80);
      drive(0, 0, 0, 2'b00);
    end
    drive(0, 1, 0, 2'b00);
    @(negedge clk);
    chk("pend_done_flush", {31'd0, ifid_flush}, 1);
    step();
    chk("pend_done_pc", pc, 32'h200);
    chk("pend_done_cnt", {16'd0, redirect_cnt}, 1);

    // stalled jr is ignored, then taken
    drive(1, 1, 1, 2'b11);
    @(negedge clk);
    chk("stall_write", {31'd0, ifid_write}, 0);
    chk("stall_flush", {31'd0, ifid_flush}, 0);
    step();
    chk("stall_pc", pc, 32'h200);
    chk("stall_cnt", {16'd0, redirect_cnt}, 1);
    drive(0, 1, 1, 2'b11);
    step();
    chk("jr_pc", pc, 32'h300);
    chk("jr_cnt", {16'd0, redirect_cnt}, 2);

    // asynchronous reset while a redirect to 0x500 is pending
    br_target = 32'h500;
    drive(0, 0, 1, 2'b10);
    step();
    chk("pend500_pc", pc, 32'h300);
    chk("pend500_cnt", {16'd0, redirect_cnt}, 3);
    rst = 1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_cnt", {16'd0, redirect_cnt}, 0);
    chk("arst_req", {31'd0, imem_req}, 0);
    drive(0, 1, 0, 2'b00);
    step();
    rst = 0;
    @(negedge clk);
    chk("arst_boot_req", {31'd0, imem_req}, 0);
    step();
    chk("arst_fetch_pc", pc, 32'h0);
    @(negedge clk);
    chk("arst_fetch_req", {31'd0, imem_req}, 1);
    step();
    chk("arst_next_pc", pc, 32'h4);

    // counter saturation
    reset_boot();
    jr_addr = 32'h100;
    drive(0, 1, 1, 2'b11);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, redirect_cnt}, 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("sat%0d", k), {16'd0, redirect_cnt}, 32'hFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 pc_src  input  2  SHALL be the branch-unit select: 00 = PC+4, 01 = j/jal, 10 = conditional branch, 11 = jr/jalr.
REQ-005 if_flush  input  1  SHALL be the branch-unit taken/flush flag.
REQ-006 id_pc4  input  32  SHALL be the PC+4 of the instruction in ID.
REQ-007 j_index  input  26  SHALL be the jump index field of the instruction in ID.
REQ-008 br_target  input  32  SHALL be the computed branch target.
REQ-009 jr_addr  input  32  SHALL be the rs register value for jr/jalr.
REQ-010 stall  input  1  SHALL be the hazard-unit stall request.
REQ-011 imem_ready  input  1  SHALL indicate the instruction memory completes the current fetch this cycle.
REQ-012 imem_req  output  1  SHALL request a fetch at pc.
REQ-013 pc  output  32  SHALL be the fetch address.
REQ-014 pc_plus4  output  32  SHALL equal pc + 4, modulo 2^32.
REQ-015 ifid_write  output  1  SHALL enable the IF/ID register load.
REQ-016 ifid_flush  output  1  SHALL force the IF/ID register load to a NOP.
REQ-017 redirect_cnt  output  16  SHALL count accepted redirects.

Function
REQ-018 redirect SHALL be asserted when if_flush=1 and pc_src!=00; if_flush=1 with pc_src=00, or pc_src!=00 with if_flush=0, SHALL NOT redirect.
REQ-019 target SHALL be selected as 01 -> {id_pc4[31:28], j_index, 2'b00}, 10 -> br_target, 11 -> jr_addr.
REQ-020 The FSM SHALL have three states: BOOT, FETCH and PEND, plus a 32-bit pend_pc register.
REQ-021 BOOT: imem_req=0, ifid_write=0 and ifid_flush=0; the FSM SHALL go unconditionally to FETCH on the next edge.
REQ-022 In FETCH and PEND, imem_req SHALL be 1 every cycle, and ifid_write SHALL equal imem_ready & !stall.
REQ-023 FETCH, stall=1: pc SHALL hold, ifid_write=0, and any redirect SHALL be ignored (not counted, no state change).
REQ-024 FETCH, stall=0, imem_ready=1, no redirect: pc SHALL become pc+4 and ifid_flush SHALL be 0.
REQ-025 FETCH, stall=0, imem_ready=1, redirect: pc SHALL become target, ifid_flush=1 the same cycle, and the FSM SHALL stay in FETCH.
REQ-026 FETCH, stall=0, imem_ready=0, redirect: pend_pc SHALL be loaded with target, pc SHALL hold, and the FSM SHALL go to PEND.
REQ-027 FETCH, stall=0, imem_ready=0, no redirect: all state SHALL hold.
REQ-028 PEND: redirect SHALL be ignored; when imem_ready=1 and stall=0, pc SHALL be loaded with pend_pc, ifid_flush=1, and the FSM SHALL go to FETCH; otherwise all state SHALL hold and ifid_flush=0.
REQ-029 ifid_flush SHALL be 0 in every case not covered by REQ-025 and REQ-028.
REQ-030 redirect_cnt SHALL increment by one on each edge where REQ-025 or REQ-026 applies, and SHALL saturate at 16'hFFFF.
REQ-031 ifid_flush and ifid_write SHALL be combinational from state and inputs; pc, pend_pc, the FSM state and redirect_cnt SHALL be registered.

Reset
REQ-032 While rst=1, the block SHALL asynchronously force state=BOOT, pc=RESET_PC, pend_pc=0 and redirect_cnt=0; imem_req, ifid_write and ifid_flush SHALL be 0.
REQ-033 Reset asserted in any state, including PEND, SHALL discard any pending redirect; after release, the first fetch SHALL be at RESET_PC.

Verification
REQ-034 Release rst, imem_ready=1, no redirect -> BOOT for 1 cycle with imem_req=0, then pc = 0, 4, 8, 12 on successive edges.
REQ-035 pc=0x40, id_pc4=0x9000_0010, pc_src=01, if_flush=1, imem_ready=1 -> ifid_flush=1 that cycle, next pc=0x9000_0000|(j_index<<2), redirect_cnt=1.
REQ-036 pc=0x80, pc_src=10, br_target=0x200, if_flush=1, imem_ready=0 for 3 cycles then 1 -> PEND, pc stays 0x80, ifid_flush=1 only on the completing cycle, next pc=0x200, redirect_cnt=1.
REQ-037 stall=1 with pc_src=11, if_flush=1, jr_addr=0x300 -> pc held, ifid_write=0, redirect_cnt unchanged; drop stall -> pc becomes 0x300.
REQ-038 Assert rst while in PEND with pend_pc=0x500 -> pc=RESET_PC, redirect_cnt=0 immediately (asynchronously); after release the sequence is BOOT then FETCH at RESET_PC, never 0x500.
REQ-039 Preload redirect_cnt to 16'hFFFE and apply 3 accepted redirects -> redirect_cnt reads FFFF and stays FFFF.
